pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: run/halt/fault sequencing, hazard controls
// (load-use stall, RET bubble, branch mispredict squash, exception
// freezing) and saturating performance counters.
module pipe_ctrl #(
    parameter int          CNT_W       = 32,
    parameter logic [3:0]  ICODE_HALT  = 4'd0,
    parameter logic [3:0]  ICODE_NOP   = 4'd1,
    parameter logic [3:0]  ICODE_MRMOVQ= 4'd5,
    parameter logic [3:0]  ICODE_OPQ   = 4'd6,
    parameter logic [3:0]  ICODE_JXX   = 4'd7,
    parameter logic [3:0]  ICODE_CALL  = 4'd8,
    parameter logic [3:0]  ICODE_RET   = 4'd9,
    parameter logic [3:0]  ICODE_POPQ  = 4'd11,
    parameter logic [3:0]  STAT_AOK    = 4'd1,
    parameter logic [3:0]  STAT_HLT    = 4'd2,
    parameter logic [3:0]  STAT_ADR    = 4'd3,
    parameter logic [3:0]  STAT_INS    = 4'd4,
    parameter logic [3:0]  RNONE       = 4'd15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [3:0]       cpu_stat,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] misp_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_faultStat;
    logic [CNT_W-1:0] r_cycCnt;
    logic [CNT_W-1:0] r_retCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_mispCnt;

    logic w_run;
    logic w_loadUse;
    logic w_retPending;
    logic w_mispredict;
    logic w_excM;
    logic w_excW;
    logic w_retire;
    logic w_callSeen;

    function automatic logic isExc(input logic [3:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

    // Hazard detection terms, all from current-cycle stage contents
    always_comb begin
        w_run        = (r_state == RUN);
        w_loadUse    = ((E_icode == ICODE_MRMOVQ) || (E_icode == ICODE_POPQ)) &&
                       (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_retPending = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) ||
                       (M_icode == ICODE_RET);
        w_mispredict = (E_icode == ICODE_JXX) && !e_Cnd;
        w_excM       = isExc(m_stat);
        w_excW       = isExc(W_stat);
        w_retire     = (W_stat == STAT_AOK) && (W_icode != ICODE_NOP) &&
                       (W_icode != ICODE_HALT);
        // CALL needs no special handling; it retires like any other instruction
        w_callSeen   = (W_icode == ICODE_CALL);
    end

    // State register; the W status is captured when entering FAULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_faultStat <= STAT_AOK;
        end else begin
            r_state <= w_nextState;
            if (w_run && (w_nextState == FAULT)) begin
                r_faultStat <= W_stat;
            end
        end
    end

    // Next-state logic: HALT and FAULT are terminal until reset
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN: begin
                if (W_stat == STAT_HLT) begin
                    w_nextState = HALT;
                end else if ((W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
                    w_nextState = FAULT;
                end
            end
            default: w_nextState = r_state;
        endcase
    end

    // Pipeline-register controls; outside RUN everything is frozen
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        if (w_run) begin
            F_stall  = w_loadUse || w_retPending;
            D_stall  = w_loadUse;
            D_bubble = w_mispredict || (w_retPending && !w_loadUse);
            E_bubble = w_mispredict || w_loadUse;
            M_bubble = w_excM || w_excW;
            W_stall  = w_excW;
            set_cc   = (E_icode == ICODE_OPQ) && !w_excM && !w_excW;
        end
    end

    // Architectural status and completion flag
    always_comb begin
        cpu_stat = STAT_AOK;
        done     = 1'b0;
        case (r_state)
            HALT: begin
                cpu_stat = STAT_HLT;
                done     = 1'b1;
            end
            FAULT: begin
                cpu_stat = r_faultStat;
                done     = 1'b1;
            end
            default: begin
                cpu_stat = STAT_AOK;
                done     = 1'b0;
            end
        endcase
    end

    // Saturating performance counters, only advancing while in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycCnt   <= '0;
            r_retCnt   <= '0;
            r_stallCnt <= '0;
            r_mispCnt  <= '0;
        end else if (w_run) begin
            if (r_cycCnt != CNT_MAX) r_cycCnt <= r_cycCnt + CNT_ONE;
            if (w_retire && (r_retCnt != CNT_MAX)) r_retCnt <= r_retCnt + CNT_ONE;
            if (w_loadUse && (r_stallCnt != CNT_MAX)) r_stallCnt <= r_stallCnt + CNT_ONE;
            if (w_mispredict && (r_mispCnt != CNT_MAX)) r_mispCnt <= r_mispCnt + CNT_ONE;
        end
    end

    assign cyc_cnt   = r_cycCnt;
    assign ret_cnt   = r_retCnt;
    assign stall_cnt = r_stallCnt;
    assign misp_cnt  = r_mispCnt;

    logic w_unused;
    assign w_unused = w_callSeen;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reset values, a table of hazard
// vectors in RUN, and hand-written fault / halt / reset / saturation
// sequences. A second instance with 4-bit counters covers saturation.
module tb_pipe_ctrl;

    localparam logic [3:0] I_HALT = 4'd0, I_NOP = 4'd1, I_MRMOVQ = 4'd5,
                           I_OPQ = 4'd6, I_JXX = 4'd7, I_RET = 4'd9, I_POPQ = 4'd11;
    localparam logic [3:0] S_AOK = 4'd1, S_HLT = 4'd2, S_ADR = 4'd3, S_INS = 4'd4;
    localparam logic [3:0] RN = 4'd15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] D_icode = I_NOP, E_icode = I_NOP, M_icode = I_NOP, W_icode = I_NOP;
    logic [3:0] d_srcA = RN, d_srcB = RN, E_dstM = RN;
    logic e_Cnd = 1'b1;
    logic [3:0] m_stat = S_AOK, W_stat = S_AOK;

    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, done;
    logic [3:0] cpu_stat;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, misp_cnt;

    logic F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4, done4;
    logic [3:0] cpu_stat4;
    logic [3:0] cyc_cnt4, ret_cnt4, stall_cnt4, misp_cnt4;

    int compared = 0;
    int mismatched = 0;
    int expCyc, expRet, expStall, expMisp;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .cpu_stat(cpu_stat), .done(done),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .misp_cnt(misp_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4), .E_bubble(E_bubble4),
        .M_bubble(M_bubble4), .W_stall(W_stall4), .set_cc(set_cc4),
        .cpu_stat(cpu_stat4), .done(done4),
        .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4), .stall_cnt(stall_cnt4), .misp_cnt(misp_cnt4)
    );

    typedef struct {
        logic [3:0] dI, eI, mI, wI, srcA, srcB, dstM;
        logic       eCnd;
        logic [3:0] mStat, wStat;
        logic [6:0] expCtl;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
        int         incRet, incStall, incMisp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] ctl();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        D_icode = v.dI; E_icode = v.eI; M_icode = v.mI; W_icode = v.wI;
        d_srcA = v.srcA; d_srcB = v.srcB; E_dstM = v.dstM;
        e_Cnd = v.eCnd; m_stat = v.mStat; W_stat = v.wStat;
    endtask

    task automatic setIdleInputs();
        D_icode = I_NOP; E_icode = I_NOP; M_icode = I_NOP; W_icode = I_OPQ;
        d_srcA = RN; d_srcB = RN; E_dstM = RN; e_Cnd = 1'b1;
        m_stat = S_AOK; W_stat = S_AOK;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cyc"}, cyc_cnt, expCyc);
        checkOutput({tag, "_ret"}, ret_cnt, expRet);
        checkOutput({tag, "_stall"}, stall_cnt, expStall);
        checkOutput({tag, "_misp"}, misp_cnt, expMisp);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] dI, eI, mI, wI, srcA, srcB, dstM,
                                input logic eCnd, input logic [3:0] mStat,
                                input logic [6:0] expCtl, input int r, s, m);
        vec_t v;
        v.dI = dI; v.eI = eI; v.mI = mI; v.wI = wI;
        v.srcA = srcA; v.srcB = srcB; v.dstM = dstM; v.eCnd = eCnd;
        v.mStat = mStat; v.wStat = S_AOK; v.expCtl = expCtl;
        v.incRet = r; v.incStall = s; v.incMisp = m;
        return v;
    endfunction

    initial begin
        //            D      E        M      W       srcA srcB dstM Cnd mStat  ctl         r s m
        vecs[0]  = mk(I_NOP, I_NOP,    I_NOP, I_OPQ,  RN,  RN,  RN,  1, S_AOK, 7'b0000000, 1,0,0);
        vecs[1]  = mk(I_NOP, I_OPQ,    I_NOP, I_OPQ,  RN,  RN,  RN,  1, S_AOK, 7'b0000001, 1,0,0);
        vecs[2]  = mk(I_RET, I_MRMOVQ, I_NOP, I_OPQ,  RN,  4'd3,4'd3,1, S_AOK, 7'b1101000, 1,1,0);
        vecs[3]  = mk(I_NOP, I_JXX,    I_NOP, I_OPQ,  RN,  RN,  RN,  0, S_AOK, 7'b0011000, 1,0,1);
        vecs[4]  = mk(I_NOP, I_JXX,    I_NOP, I_OPQ,  RN,  RN,  RN,  1, S_AOK, 7'b0000000, 1,0,0);
        vecs[5]  = mk(I_NOP, I_NOP,    I_RET, I_OPQ,  RN,  RN,  RN,  1, S_AOK, 7'b1010000, 1,0,0);
        vecs[6]  = mk(I_NOP, I_POPQ,   I_NOP, I_NOP,  RN,  RN,  RN,  1, S_AOK, 7'b0000000, 0,0,0);
        vecs[7]  = mk(I_NOP, I_POPQ,   I_NOP, I_HALT, 4'd4,RN,  4'd4,1, S_AOK, 7'b1101000, 0,1,0);
        vecs[8]  = mk(I_NOP, I_OPQ,    I_NOP, I_OPQ,  RN,  RN,  RN,  1, S_ADR, 7'b0000100, 1,0,0);
        vecs[9]  = mk(I_NOP, I_MRMOVQ, I_NOP, I_OPQ,  4'd5,4'd6,4'd3,1, S_INS, 7'b0000100, 1,0,0);
        vecs[10] = mk(I_RET, I_JXX,    I_NOP, I_OPQ,  RN,  RN,  RN,  0, S_AOK, 7'b1011000, 1,0,1);

        // Reset state
        setIdleInputs();
        tick();
        checkOutput("rst_ctl", ctl(), 7'b1100010);
        checkOutput("rst_cpu_stat", cpu_stat, S_AOK);
        checkOutput("rst_done", done, 0);
        expCyc = 0; expRet = 0; expStall = 0; expMisp = 0;
        checkCounters("rst");
        tick();
        rst_n = 1'b1;

        // Idle without start stays idle
        tick();
        tick();
        checkOutput("idle_ctl", ctl(), 7'b1100010);
        checkOutput("idle_cyc", cyc_cnt, 0);

        // Start then ten OPQ retirements
        pulseStart();
        E_icode = I_OPQ;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 0) checkOutput("run_opq_ctl", ctl(), 7'b0000001);
            tick();
        end
        expCyc = 10; expRet = 10;
        checkCounters("run10");

        // Hazard table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ctl", i), ctl(), vecs[i].expCtl);
            tick();
            expCyc++;
            expRet   += vecs[i].incRet;
            expStall += vecs[i].incStall;
            expMisp  += vecs[i].incMisp;
            checkCounters($sformatf("vec%0d", i));
        end

        // W_stat=ADR arrives: freeze writeback, then fault
        setIdleInputs();
        E_icode = I_OPQ;
        W_stat = S_ADR;
        #1;
        checkOutput("wadr_ctl", ctl(), 7'b0000110);
        tick();
        expCyc++;
        checkCounters("wadr");
        checkOutput("fault_cpu_stat", cpu_stat, S_ADR);
        checkOutput("fault_done", done, 1);
        checkOutput("fault_ctl", ctl(), 7'b1100010);
        setIdleInputs();
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        checkCounters("fault_frozen");
        checkOutput("fault_hold_cpu_stat", cpu_stat, S_ADR);

        // Reset, run a little, then async reset between edges
        rst_n = 1'b0;
        tick();
        expCyc = 0; expRet = 0; expStall = 0; expMisp = 0;
        checkCounters("rst2");
        checkOutput("rst2_cpu_stat", cpu_stat, S_AOK);
        rst_n = 1'b1;
        pulseStart();
        tick(); tick(); tick();
        checkOutput("mid_cyc", cyc_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_cyc", cyc_cnt, 0);
        checkOutput("async_ret", ret_cnt, 0);
        checkOutput("async_ctl", ctl(), 7'b1100010);
        checkOutput("async_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checkOutput("norestart_cyc", cyc_cnt, 0);
        checkOutput("norestart_ctl", ctl(), 7'b1100010);

        // Saturation on the 4-bit instance, then halt
        pulseStart();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_cyc4", cyc_cnt4, 15);
        checkOutput("sat_ret4", ret_cnt4, 15);
        checkOutput("sat_cyc32", cyc_cnt, 20);
        W_stat = S_HLT;
        tick();
        W_stat = S_AOK;
        checkOutput("halt_cpu_stat", cpu_stat, S_HLT);
        checkOutput("halt_done", done, 1);
        checkOutput("halt_cyc32", cyc_cnt, 21);
        checkOutput("halt_ret32", ret_cnt, 20);
        checkOutput("halt_cyc4", cyc_cnt4, 15);
        checkOutput("halt_cpu_stat4", cpu_stat4, S_HLT);
        pulseStart();
        tick();
        checkOutput("halt_start_cpu_stat", cpu_stat, S_HLT);
        checkOutput("halt_start_cyc", cyc_cnt, 21);
        checkOutput("halt_start_ctl", ctl(), 7'b1100010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
